// File: rtl/multi_scrolling_graph.sv
// Multi-channel scrolling oscilloscope overlay: per-channel sample rings drawn as stacked
// bar/line traces. Define SCROLLING_GRAPH_GRID_EN to add the 64-column / 32-row graticule.
module multi_scrolling_graph #(
  parameter int          SCREEN_WIDTH    = 1280,
  parameter int          SCREEN_HEIGHT   = 720,
  parameter int          DATA_RESOLUTION = 8,
  parameter int          NUM_CHANNELS    = 2,
  parameter int          SCALE_SHIFT     = 0,
  parameter logic [23:0] TRACE_COLOR     = 24'h0000FF
) (
  input  logic                                      clk_in,
  input  logic                                      rst_n_in,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]           hcount_in,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0]          vcount_in,
  input  logic [NUM_CHANNELS-1:0]                   data_valid_in,
  input  logic [NUM_CHANNELS*DATA_RESOLUTION-1:0]   data_in,
  input  logic                                      mode_in,
  input  logic                                      freeze_in,
  output logic                                      pixel_valid_out,
  output logic [23:0]                               pixel_out
);

  localparam int HW     = $clog2(SCREEN_WIDTH);
  localparam int DR     = DATA_RESOLUTION;
  localparam int BAND_H = SCREEN_HEIGHT / NUM_CHANNELS;
  localparam int HALF   = BAND_H / 2;
  localparam int LIMIT  = HALF - 1;
  localparam int CW     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [23:0] AXIS_COLOR = 24'hFFFFFF;

  logic [DR-1:0] mem [NUM_CHANNELS][SCREEN_WIDTH];
  logic [HW-1:0] wr_ptr    [NUM_CHANNELS];
  logic [HW-1:0] frame_ptr [NUM_CHANNELS];

  logic frame_start;
  assign frame_start = (hcount_in == '0) && (vcount_in == '0);

  // Sample storage deliberately has no reset so history survives a pointer restart.
  always_ff @(posedge clk_in) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!freeze_in && data_valid_in[c]) begin
        mem[c][wr_ptr[c]] <= data_in[c*DR +: DR];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wr_ptr[c]    <= '0;
        frame_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (!freeze_in && data_valid_in[c]) begin
          wr_ptr[c] <= (wr_ptr[c] == HW'(SCREEN_WIDTH - 1)) ? '0 : wr_ptr[c] + HW'(1);
        end
        if (frame_start) begin
          frame_ptr[c] <= wr_ptr[c];
        end
      end
    end
  end

  // Stage 0: locate band, form read addresses and signed row offset.
  int            h_int, v_int, band;
  logic          in_band;
  logic [CW-1:0] ch_sel;
  logic [HW-1:0] fp_sel;
  logic [HW-1:0] cur_addr, prev_addr;
  int            d_int;

  always_comb begin
    h_int   = int'(hcount_in);
    v_int   = int'(vcount_in);
    band    = v_int / BAND_H;
    in_band = v_int < NUM_CHANNELS * BAND_H;
    ch_sel  = in_band ? CW'(band) : '0;
    // The origin pixel already belongs to the new frame, so use the live pointer there.
    fp_sel  = frame_start ? wr_ptr[ch_sel] : frame_ptr[ch_sel];
    cur_addr  = HW'((int'(fp_sel) + h_int) % SCREEN_WIDTH);
    prev_addr = (h_int == 0) ? cur_addr
                             : HW'((int'(fp_sel) + h_int + SCREEN_WIDTH - 1) % SCREEN_WIDTH);
    d_int   = int'(ch_sel) * BAND_H + HALF - v_int;
  end

  logic          s1_valid, s1_in_band, s1_mode;
  int            s1_d;
  logic [DR-1:0] s1_cur, s1_prev;
`ifdef SCROLLING_GRAPH_GRID_EN
  logic          s1_col_grid;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= 1'b1;
    end
    s1_in_band <= in_band;
    s1_mode    <= mode_in;
    s1_d       <= d_int;
    s1_cur     <= mem[ch_sel][cur_addr];
    s1_prev    <= mem[ch_sel][prev_addr];
`ifdef SCROLLING_GRAPH_GRID_EN
    s1_col_grid <= (hcount_in[5:0] == 6'd0);
`endif
  end

  function automatic int clamp_sample(input logic [DR-1:0] raw);
    int x;
    x = int'($signed(raw)) >>> SCALE_SHIFT;
    if (x > LIMIT) x = LIMIT;
    if (x < -LIMIT) x = -LIMIT;
    return x;
  endfunction

  // Stage 1: scale/clamp, evaluate trace geometry and colour priority.
  int          s_val, p_val, lo, hi, d_abs;
  logic        bar_lit, line_lit, lit, axis, grid;
  logic [23:0] color;

  always_comb begin
    s_val    = clamp_sample(s1_cur);
    p_val    = clamp_sample(s1_prev);
    lo       = (p_val < s_val) ? p_val : s_val;
    hi       = (p_val < s_val) ? s_val : p_val;
    d_abs    = (s1_d < 0) ? -s1_d : s1_d;
    bar_lit  = ((s1_d > 0) && (s_val > 0) && (s1_d <= s_val)) ||
               ((s1_d < 0) && (s_val < 0) && (s1_d >= s_val));
    line_lit = (s1_d >= lo) && (s1_d <= hi);
    lit      = s1_in_band && (s1_mode ? line_lit : bar_lit);
    axis     = s1_in_band && (s1_d == 0);
`ifdef SCROLLING_GRAPH_GRID_EN
    grid     = s1_in_band && (s1_col_grid || ((d_abs % 32) == 0));
`else
    grid     = 1'b0;
`endif
    if (lit) begin
      color = TRACE_COLOR;
    end else if (axis) begin
      color = AXIS_COLOR;
    end else if (grid) begin
      color = 24'h404040;
    end else begin
      color = 24'h000000;
    end
  end

  logic        s2_valid;
  logic [23:0] s2_color;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s2_valid        <= 1'b0;
      s2_color        <= '0;
      pixel_valid_out <= 1'b0;
      pixel_out       <= '0;
    end else begin
      s2_valid        <= s1_valid;
      s2_color        <= color;
      pixel_valid_out <= s2_valid;
      pixel_out       <= s2_color;
    end
  end

endmodule

// File: tb/tb_multi_scrolling_graph.sv
// Bench for multi_scrolling_graph: table-driven pixel probes checked through a 3-deep
// scoreboard queue, against a default 2-channel instance and a 4-channel instance.
module tb_multi_scrolling_graph;

  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount = 11'd5;
  logic [9:0]  vcount = 10'd5;
  logic [1:0]  dv = '0;
  logic [15:0] din = '0;
  logic [3:0]  dv4 = '0;
  logic [31:0] din4 = '0;
  logic        mode = 1'b0;
  logic        frz = 1'b0;
  logic        pv, pv4;
  logic [23:0] pix, pix4;

  always #5 clk = ~clk;

  multi_scrolling_graph u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .data_valid_in(dv), .data_in(din), .mode_in(mode), .freeze_in(frz),
    .pixel_valid_out(pv), .pixel_out(pix)
  );

  multi_scrolling_graph #(.NUM_CHANNELS(4)) u_dut4 (
    .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .data_valid_in(dv4), .data_in(din4), .mode_in(mode), .freeze_in(frz),
    .pixel_valid_out(pv4), .pixel_out(pix4)
  );

  typedef struct {
    int          h;
    int          v;
    logic        mode;
    logic        sel;
    logic [23:0] col;
    string       name;
  } vec_t;

  typedef struct {
    logic        chk;
    logic        sel;
    logic [23:0] col;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int h, input int v, input logic m, input logic s,
                              input logic [23:0] c, input string n);
    vec_t t;
    t.h = h; t.v = v; t.mode = m; t.sel = s; t.col = c; t.name = n;
    return t;
  endfunction

  // One pixel clock: retire the probe issued 3 cycles ago, then present the next one.
  task automatic cycle(input int h, input int v, input logic m, input logic chk,
                       input logic sel, input logic [23:0] col, input string name);
    exp_t e;
    logic [23:0] act;
    logic        act_v;
    @(negedge clk);
    dv  = '0;
    dv4 = '0;
    if (sbq.size() >= 3) begin
      e = sbq.pop_front();
      if (e.chk) begin
        act   = e.sel ? pix4 : pix;
        act_v = e.sel ? pv4 : pv;
        n_checks++;
        if (act !== e.col || act_v !== 1'b1) begin
          n_fail++;
          $display("FAIL %s: got pixel %h valid %b, want pixel %h valid 1",
                   e.name, act, act_v, e.col);
        end
      end
    end
    hcount = 11'(h);
    vcount = 10'(v);
    mode   = m;
    e.chk = chk; e.sel = sel; e.col = col; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(5, 5, 1'b0, 1'b0, 1'b0, BLACK, "idle");
  endtask

  task automatic wr(input logic [1:0] mask, input int v0, input int v1);
    dv  = mask;
    din = {8'(v1), 8'(v0)};
    idle(1);
  endtask

  task automatic run(input vec_t tab[$]);
    foreach (tab[i]) cycle(tab[i].h, tab[i].v, tab[i].mode, 1'b1, tab[i].sel, tab[i].col,
                           tab[i].name);
  endtask

  vec_t ph_a[$], ph_b[$], ph_c[$], ph_d[$], ph_e[$];

  initial begin
    ph_a.push_back(mk(0,    0,   0, 0, BLACK, "a_origin"));
    ph_a.push_back(mk(1279, 130, 0, 0, BLUE,  "a_bar_new_top"));
    ph_a.push_back(mk(1279, 129, 0, 0, BLACK, "a_bar_new_above"));
    ph_a.push_back(mk(1279, 179, 0, 0, BLUE,  "a_bar_new_bottom"));
    ph_a.push_back(mk(1279, 180, 0, 0, WHITE, "a_axis0"));
    ph_a.push_back(mk(1279, 181, 0, 0, BLACK, "a_below_axis0"));
    ph_a.push_back(mk(0,    170, 0, 0, BLUE,  "a_bar_old_top"));
    ph_a.push_back(mk(0,    169, 0, 0, BLACK, "a_bar_old_above"));
    ph_a.push_back(mk(640,  175, 0, 0, BLUE,  "a_bar_mid"));
    ph_a.push_back(mk(1279, 541, 0, 0, BLUE,  "a_ch1_top"));
    ph_a.push_back(mk(1279, 560, 0, 0, BLUE,  "a_ch1_bottom"));
    ph_a.push_back(mk(1279, 540, 0, 0, WHITE, "a_axis1"));
    ph_a.push_back(mk(1279, 561, 0, 0, BLACK, "a_ch1_past"));
    ph_a.push_back(mk(1279, 720, 0, 0, BLACK, "a_below_bands"));
    ph_a.push_back(mk(1279, 171, 1, 0, BLACK, "a_line_gap"));
    ph_a.push_back(mk(1279, 171, 0, 0, BLUE,  "a_bar_after_line"));
    ph_a.push_back(mk(1279, 170, 1, 0, BLUE,  "a_line_low"));
    ph_a.push_back(mk(0,    170, 1, 0, BLUE,  "a_line_col0"));
    ph_a.push_back(mk(0,    171, 1, 0, BLACK, "a_line_col0_gap"));
    ph_a.push_back(mk(1279, 1,   0, 1, BLUE,  "a_ch4_clamp_top"));
    ph_a.push_back(mk(1279, 0,   0, 1, BLACK, "a_ch4_clamp_edge"));
    ph_a.push_back(mk(1279, 89,  0, 1, BLUE,  "a_ch4_bottom"));
    ph_a.push_back(mk(1279, 90,  0, 1, WHITE, "a_ch4_axis"));

    ph_b.push_back(mk(0,    0,   1, 0, BLACK, "b_origin"));
    ph_b.push_back(mk(1279, 155, 1, 0, BLUE,  "b_line_top"));
    ph_b.push_back(mk(1279, 175, 1, 0, BLUE,  "b_line_bottom"));
    ph_b.push_back(mk(1279, 154, 1, 0, BLACK, "b_line_above"));
    ph_b.push_back(mk(1279, 176, 1, 0, BLACK, "b_line_below"));
    ph_b.push_back(mk(1279, 180, 1, 0, WHITE, "b_axis"));

    ph_c.push_back(mk(0,    0,   0, 0, BLACK, "c_origin"));
    ph_c.push_back(mk(1279, 155, 0, 0, BLUE,  "c_frz_bar"));
    ph_c.push_back(mk(1279, 130, 0, 0, BLACK, "c_frz_no_new"));
    ph_c.push_back(mk(1279, 155, 1, 0, BLUE,  "c_frz_line"));
    ph_c.push_back(mk(1279, 154, 1, 0, BLACK, "c_frz_line_edge"));

    ph_d.push_back(mk(0,    0,   0, 0, BLACK, "d_origin"));
    ph_d.push_back(mk(1279, 53,  0, 0, BLUE,  "d_big_top"));
    ph_d.push_back(mk(1279, 52,  0, 0, BLACK, "d_big_above"));
    ph_d.push_back(mk(1279, 179, 0, 0, BLUE,  "d_big_bottom"));

    ph_e.push_back(mk(0,    0,   0, 0, BLACK, "e_origin"));
    ph_e.push_back(mk(1279, 170, 0, 0, BLUE,  "e_keep_top"));
    ph_e.push_back(mk(1279, 169, 0, 0, BLACK, "e_keep_above"));
    ph_e.push_back(mk(1,    175, 0, 0, BLUE,  "e_col1_top"));
    ph_e.push_back(mk(1,    174, 0, 0, BLACK, "e_col1_above"));

    // Reset: outputs held at zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (pix !== BLACK || pv !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: got pixel %h valid %b, want pixel 000000 valid 0", pix, pv);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (pv !== (k == 3)) begin
        n_fail++;
        $display("FAIL valid_rise_%0d: got valid %b, want %b", k, pv, (k == 3));
      end
    end

    // Fill channel 0 with 10, then a simultaneous strobe: ch0=50, ch1=-20.
    dv4  = 4'b0001;
    din4 = {24'h0, 8'd127};
    idle(1);
    for (int i = 0; i < 1280; i++) wr(2'b01, 10, 0);
    wr(2'b11, 50, -20);
    idle(2);
    run(ph_a);

    wr(2'b01, 5, 0);
    wr(2'b01, 25, 0);
    run(ph_b);

    frz = 1'b1;
    wr(2'b11, 100, 100);
    wr(2'b11, 100, 100);
    run(ph_c);
    idle(3);
    frz = 1'b0;

    wr(2'b01, 127, 0);
    run(ph_d);

    // Mid-run reset restarts pointers but keeps stored history.
    idle(3);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(4);
    run(ph_e);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
